// File: rtl/axi_stream_strip.sv
// Strips a 0..DATA_BYTE_WD-1 byte header into a header beat and left-aligns the payload; AXI_STREAM_STRIP_KEEP_CHECK_EN adds a sticky keep check.
// Latency: payload beat k registers once input beat k+1 (or the last) is accepted; at most one FLUSH bubble per packet.
// Backpressure: output channels hold while valid&&!ready; FIRST beat stalls until the previous header is consumed.
module axi_stream_strip #(
    parameter int DATA_WD      = 32,
    parameter int DATA_BYTE_WD = DATA_WD >> 3,
    parameter int BYTE_CNT_WD  = $clog2(DATA_BYTE_WD)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    valid_cmd,
    input  logic [BYTE_CNT_WD-1:0]  byte_strip_cnt,
    output logic                    ready_cmd,
    input  logic                    valid_in,
    input  logic [DATA_WD-1:0]      data_in,
    input  logic [DATA_BYTE_WD-1:0] keep_in,
    input  logic                    last_in,
    output logic                    ready_in,
    output logic                    valid_out,
    output logic [DATA_WD-1:0]      data_out,
    output logic [DATA_BYTE_WD-1:0] keep_out,
    output logic                    last_out,
    input  logic                    ready_out,
    output logic                    valid_header,
    output logic [DATA_WD-1:0]      data_header,
    output logic [DATA_BYTE_WD-1:0] keep_header,
    input  logic                    ready_header,
    output logic                    err_keep
);
    localparam int CNT_WD = BYTE_CNT_WD + 1;

    typedef enum logic [1:0] {IDLE, FIRST, STREAM, FLUSH} state_t;

    function automatic logic [DATA_BYTE_WD-1:0] top_mask(input logic [CNT_WD-1:0] cnt);
        logic [DATA_BYTE_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            if (i < int'(cnt)) m[DATA_BYTE_WD-1-i] = 1'b1;
        return m;
    endfunction

    function automatic logic [CNT_WD-1:0] pop_cnt(input logic [DATA_BYTE_WD-1:0] k);
        logic [CNT_WD-1:0] c;
        c = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            c = c + CNT_WD'(k[i]);
        return c;
    endfunction

    function automatic logic [DATA_WD-1:0] lane_bits(input logic [DATA_BYTE_WD-1:0] k);
        logic [DATA_WD-1:0] m;
        m = '0;
        for (int i = 0; i < DATA_BYTE_WD; i++)
            m[i*8 +: 8] = {8{k[i]}};
        return m;
    endfunction

    state_t                  state, state_nxt;
    logic [BYTE_CNT_WD-1:0]  strip_n;
    logic [CNT_WD-1:0]       n_ext;
    logic [DATA_WD-1:0]      res_dat;
    logic [CNT_WD-1:0]       res_cnt;

    logic                    cmd_fire, in_fire, out_free;
    logic [DATA_WD-1:0]      data_m, data_up, data_dn;
    logic [CNT_WD-1:0]       in_cnt, left_cnt;
    logic [DATA_BYTE_WD-1:0] hdr_mask;
    logic                    out_load, res_load, hdr_load;
    logic [DATA_WD-1:0]      out_dat_nxt;
    logic [DATA_BYTE_WD-1:0] out_keep_nxt;
    logic                    out_last_nxt;

    assign n_ext    = {1'b0, strip_n};
    assign cmd_fire = valid_cmd && ready_cmd;
    assign in_fire  = valid_in && ready_in;
    assign out_free = !valid_out || ready_out;
    // Lanes outside keep are zeroed once here so every shifted copy is already clean.
    assign data_m   = data_in & lane_bits(keep_in);
    assign in_cnt   = pop_cnt(keep_in);
    assign left_cnt = (in_cnt > n_ext) ? in_cnt - n_ext : '0;
    assign hdr_mask = top_mask(n_ext);
    assign data_up  = data_m << {n_ext, 3'b000};
    assign data_dn  = data_m >> {CNT_WD'(DATA_BYTE_WD) - n_ext, 3'b000};

    always_comb begin
        state_nxt    = state;
        ready_in     = 1'b0;
        out_load     = 1'b0;
        res_load     = 1'b0;
        hdr_load     = 1'b0;
        out_dat_nxt  = '0;
        out_keep_nxt = '0;
        out_last_nxt = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_fire) state_nxt = FIRST;
            end
            FIRST: begin
                ready_in = !valid_header;
                if (in_fire) begin
                    res_load  = 1'b1;
                    hdr_load  = (strip_n != '0);
                    state_nxt = last_in ? FLUSH : STREAM;
                end
            end
            STREAM: begin
                ready_in = out_free;
                if (in_fire) begin
                    out_load     = 1'b1;
                    res_load     = 1'b1;
                    out_dat_nxt  = res_dat | data_dn;
                    out_keep_nxt = '1;
                    if (last_in) begin
                        // Short last beat fits entirely behind the residue: no flush needed.
                        if (in_cnt <= n_ext) begin
                            out_keep_nxt = top_mask(CNT_WD'(DATA_BYTE_WD) - n_ext + in_cnt);
                            out_last_nxt = 1'b1;
                            state_nxt    = IDLE;
                        end else begin
                            state_nxt = FLUSH;
                        end
                    end
                end
            end
            FLUSH: begin
                if (out_free) begin
                    out_load     = 1'b1;
                    out_dat_nxt  = res_dat;
                    out_keep_nxt = top_mask(res_cnt);
                    out_last_nxt = 1'b1;
                    state_nxt    = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ready_cmd <= 1'b0;
            strip_n   <= '0;
            res_dat   <= '0;
            res_cnt   <= '0;
        end else begin
            state     <= state_nxt;
            ready_cmd <= (state_nxt == IDLE);
            if (cmd_fire) strip_n <= byte_strip_cnt;
            if (res_load) begin
                res_dat <= data_up;
                res_cnt <= left_cnt;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
            keep_out  <= '0;
            last_out  <= 1'b0;
        end else if (out_load) begin
            valid_out <= 1'b1;
            data_out  <= out_dat_nxt;
            keep_out  <= out_keep_nxt;
            last_out  <= out_last_nxt;
        end else if (ready_out) begin
            valid_out <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_header <= 1'b0;
            data_header  <= '0;
            keep_header  <= '0;
        end else if (hdr_load) begin
            valid_header <= 1'b1;
            data_header  <= data_m & lane_bits(hdr_mask);
            keep_header  <= keep_in & hdr_mask;
        end else if (ready_header) begin
            valid_header <= 1'b0;
        end
    end

`ifdef AXI_STREAM_STRIP_KEEP_CHECK_EN
    logic [DATA_BYTE_WD-1:0] keep_inv;
    logic                    keep_bad;

    // MSB-contiguous keep means its complement is a run of ones from bit 0.
    assign keep_inv = ~keep_in;
    assign keep_bad = ((keep_inv & (keep_inv + DATA_BYTE_WD'(1))) != '0) ||
                      (!last_in && (keep_in != '1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   err_keep <= 1'b0;
        else if (in_fire && keep_bad) err_keep <= 1'b1;
    end
`else
    assign err_keep = 1'b0;
`endif

endmodule

// File: tb/tb_axi_stream_strip.sv
// Randomized and directed bench for axi_stream_strip against a byte-queue packet model.
module tb_axi_stream_strip;
    localparam int BOUND = 2000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        valid_cmd = 1'b0;
    logic [1:0]  byte_strip_cnt = '0;
    logic        ready_cmd;
    logic        valid_in = 1'b0;
    logic [31:0] data_in = '0;
    logic [3:0]  keep_in = '0;
    logic        last_in = 1'b0;
    logic        ready_in;
    logic        valid_out;
    logic [31:0] data_out;
    logic [3:0]  keep_out;
    logic        last_out;
    logic        ready_out = 1'b1;
    logic        valid_header;
    logic [31:0] data_header;
    logic [3:0]  keep_header;
    logic        ready_header = 1'b1;
    logic        err_keep;

    axi_stream_strip dut (
        .clk(clk), .rst_n(rst_n),
        .valid_cmd(valid_cmd), .byte_strip_cnt(byte_strip_cnt), .ready_cmd(ready_cmd),
        .valid_in(valid_in), .data_in(data_in), .keep_in(keep_in), .last_in(last_in), .ready_in(ready_in),
        .valid_out(valid_out), .data_out(data_out), .keep_out(keep_out), .last_out(last_out), .ready_out(ready_out),
        .valid_header(valid_header), .data_header(data_header), .keep_header(keep_header), .ready_header(ready_header),
        .err_keep(err_keep)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cmd_cnt = 0;
    int          hdr_cmds = 0;
    int          pay_pkts = 0;
    int          hdr_pkts = 0;
    logic        mon_en = 1'b0;
    logic        rnd_mode = 1'b0;
    logic [31:0] beats[$];
    logic [35:0] exp_hdr[$];
    logic [36:0] exp_pay[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, act, req);
        end
    endtask

    task automatic timeout(input string name);
        n_checks++;
        n_fail++;
        $display("FAIL %s: got no handshake within %0d cycles required one", name, BOUND);
    endtask

    // Packet model: header = first n bytes, payload = the rest in 4-byte beats, or one empty last beat.
    task automatic model_pkt(input int n, input int last_cnt);
        logic [7:0]  bytes[$];
        logic [31:0] w;
        logic [31:0] d;
        logic [3:0]  k;
        int          hn;
        int          rem;
        for (int b = 0; b < beats.size(); b++) begin
            w = beats[b];
            for (int j = 0; j < ((b == beats.size() - 1) ? last_cnt : 4); j++)
                bytes.push_back(w[31-8*j -: 8]);
        end
        hn = (n < bytes.size()) ? n : bytes.size();
        if (n > 0) begin
            d = '0;
            k = '0;
            for (int i = 0; i < hn; i++) begin
                d[31-8*i -: 8] = bytes[i];
                k[3-i] = 1'b1;
            end
            exp_hdr.push_back({k, d});
        end
        rem = bytes.size() - hn;
        if (rem == 0) begin
            exp_pay.push_back({1'b1, 4'h0, 32'h0});
        end else begin
            for (int b = 0; b * 4 < rem; b++) begin
                d = '0;
                k = '0;
                for (int j = 0; j < 4; j++) begin
                    if (hn + 4 * b + j < bytes.size()) begin
                        d[31-8*j -: 8] = bytes[hn + 4 * b + j];
                        k[3-j] = 1'b1;
                    end
                end
                exp_pay.push_back({((b + 1) * 4 >= rem) ? 1'b1 : 1'b0, k, d});
            end
        end
    endtask

    // All drive tasks start and end at posedge+1.
    task automatic send_cmd(input int n);
        int t;
        valid_cmd = 1'b1;
        byte_strip_cnt = 2'(n);
        t = 0;
        @(negedge clk);
        while (!ready_cmd && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        if (!ready_cmd) timeout("cmd_accept");
        @(posedge clk);
        #1;
        valid_cmd = 1'b0;
    endtask

    task automatic drive_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int t;
        if (rnd_mode) begin
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end
        valid_in = 1'b1;
        data_in = d;
        keep_in = k;
        last_in = l;
        t = 0;
        @(negedge clk);
        while (!ready_in && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        if (!ready_in) timeout("beat_accept");
        @(posedge clk);
        #1;
        valid_in = 1'b0;
    endtask

    task automatic drive_pkt(input int n, input int last_cnt);
        send_cmd(n);
        cmd_cnt++;
        if (n > 0) hdr_cmds++;
        for (int b = 0; b < beats.size(); b++) begin
            if (b == beats.size() - 1)
                drive_beat(beats[b], 4'(4'hF << (4 - last_cnt)), 1'b1);
            else
                drive_beat(beats[b], 4'hF, 1'b0);
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        @(negedge clk);
        while ((exp_pay.size() != 0 || exp_hdr.size() != 0) && t < BOUND) begin
            @(negedge clk);
            t++;
        end
        if (exp_pay.size() != 0 || exp_hdr.size() != 0) timeout("drain");
        @(posedge clk);
        #1;
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_mode) begin
            ready_out = ($urandom_range(0, 3) != 0);
            ready_header = ($urandom_range(0, 2) != 0);
        end else begin
            ready_out = 1'b1;
            ready_header = 1'b1;
        end
    end

    // Single compare process: stall stability plus in-order scoreboard on both channels.
    initial begin
        logic        p_out_stall;
        logic        p_hdr_stall;
        logic [36:0] p_out;
        logic [35:0] p_hdr;
        p_out_stall = 1'b0;
        p_hdr_stall = 1'b0;
        p_out = '0;
        p_hdr = '0;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (p_out_stall)
                    check("payload_stable", {valid_out, last_out, keep_out, data_out}, {1'b1, p_out});
                if (p_hdr_stall)
                    check("header_stable", {valid_header, keep_header, data_header}, {1'b1, p_hdr});
                if (valid_out && ready_out) begin
                    if (exp_pay.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL payload_extra: got beat %h/%b required none", data_out, keep_out);
                    end else begin
                        check("payload_beat", {last_out, keep_out, data_out}, exp_pay.pop_front());
                    end
                    if (last_out) pay_pkts++;
                end
                if (valid_header && ready_header) begin
                    if (exp_hdr.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL header_extra: got beat %h/%b required none", data_header, keep_header);
                    end else begin
                        check("header_beat", {keep_header, data_header}, exp_hdr.pop_front());
                    end
                    hdr_pkts++;
                end
`ifndef AXI_STREAM_STRIP_KEEP_CHECK_EN
                check("err_keep_tied", err_keep, 1'b0);
`endif
                p_out_stall = valid_out && !ready_out;
                p_hdr_stall = valid_header && !ready_header;
                p_out = {last_out, keep_out, data_out};
                p_hdr = {keep_header, data_header};
            end else begin
                p_out_stall = 1'b0;
                p_hdr_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no end of test required $finish before time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        int          lc;
        logic        quiet;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready_cmd", ready_cmd, 1'b0);
        check("rst_ready_in", ready_in, 1'b0);
        check("rst_valid_out", valid_out, 1'b0);
        check("rst_data_out", data_out, 32'h0);
        check("rst_keep_out", keep_out, 4'h0);
        check("rst_last_out", last_out, 1'b0);
        check("rst_valid_header", valid_header, 1'b0);
        check("rst_data_header", data_header, 32'h0);
        check("rst_keep_header", keep_header, 4'h0);
        check("rst_err_keep", err_keep, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        mon_en = 1'b1;

        // Directed packet 1: n=1, last beat keeps two bytes, needs a flush beat.
        beats = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
        model_pkt(1, 2);
        check("pin1_hdr", exp_hdr[0], {4'b1000, 32'hA1000000});
        check("pin1_pay0", exp_pay[0], {1'b0, 4'b1111, 32'hA2A3A4B1});
        check("pin1_pay1", exp_pay[1], {1'b0, 4'b1111, 32'hB2B3B4C1});
        check("pin1_pay2", exp_pay[2], {1'b1, 4'b1000, 32'hC2000000});
        drive_pkt(1, 2);
        wait_drain();

        // Directed packet 2: n=3, last beat folds into the merged beat.
        model_pkt(3, 2);
        check("pin2_hdr", exp_hdr[0], {4'b1110, 32'hA1A2A300});
        check("pin2_pay0", exp_pay[0], {1'b0, 4'b1111, 32'hA4B1B2B3});
        check("pin2_pay1", exp_pay[1], {1'b1, 4'b1110, 32'hB4C1C200});
        check("pin2_len", exp_pay.size(), 2);
        drive_pkt(3, 2);
        wait_drain();

        // Directed packet 3: n=0 passthrough.
        beats = '{32'h11223344, 32'h55667788, 32'h99AABBCC};
        model_pkt(0, 4);
        check("pin3_nohdr", exp_hdr.size(), 0);
        check("pin3_pay2", exp_pay[2], {1'b1, 4'b1111, 32'h99AABBCC});
        drive_pkt(0, 4);
        wait_drain();

        // Directed packet 4: whole packet shorter than the header.
        beats = '{32'hD1D2D3D4};
        model_pkt(3, 2);
        check("pin4_hdr", exp_hdr[0], {4'b1100, 32'hD1D20000});
        check("pin4_pay", exp_pay[0], {1'b1, 4'b0000, 32'h0});
        drive_pkt(3, 2);
        wait_drain();

        rnd_mode = 1'b1;
        for (int p = 0; p < 200; p++) begin
            n = $urandom_range(0, 3);
            lc = $urandom_range(1, 4);
            beats.delete();
            repeat ($urandom_range(1, 4)) beats.push_back($urandom);
            model_pkt(n, lc);
            drive_pkt(n, lc);
        end
        rnd_mode = 1'b0;
        wait_drain();
        check("payload_pkt_count", pay_pkts, cmd_cnt);
        check("header_pkt_count", hdr_pkts, hdr_cmds);

        // Mid-packet reset, with a malformed keep first when the checker is built.
        mon_en = 1'b0;
        send_cmd(1);
`ifdef AXI_STREAM_STRIP_KEEP_CHECK_EN
        drive_beat(32'h01020304, 4'b1110, 1'b0);
        @(negedge clk);
        check("err_keep_set", err_keep, 1'b1);
        repeat (3) @(negedge clk);
        check("err_keep_sticky", err_keep, 1'b1);
        @(posedge clk);
        #1;
`else
        drive_beat(32'h01020304, 4'hF, 1'b0);
`endif
        drive_beat(32'h05060708, 4'hF, 1'b0);
        @(negedge clk);
        check("mid_pkt_valid_out", valid_out, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_payload", {ready_cmd, ready_in, valid_out, last_out, keep_out, data_out}, 40'h0);
        check("midrst_header", {valid_header, keep_header, data_header, err_keep}, 38'h0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        quiet = 1'b1;
        repeat (8) begin
            @(negedge clk);
            if (valid_out || last_out || valid_header) quiet = 1'b0;
        end
        check("midrst_no_output", quiet, 1'b1);
        check("midrst_ready_cmd", ready_cmd, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
